dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store port and one auxiliary master (display refresher, UART loader, or debug reader).
- CPU has fixed priority. A starvation counter guarantees the auxiliary master a slot after MAX_WAIT blocked cycles; the CPU is stalled for exactly that one cycle.
- Sits between the core's datapath memory signals and the data memory. Memory read is combinational; memory write is on the clock edge.

Parameters:
- DW, 32: data width.
- AW, 32: address width (memory decodes word address bits [7:2]).
- MAX_WAIT, 4: blocked aux cycles before a forced aux grant; must be ≥1 (elaboration error otherwise).
- WAIT_W, $clog2(MAX_WAIT+1): wait counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU issues a load or store this cycle
- cpu_we  in  1  CPU store
- cpu_a  in  AW  CPU byte address
- cpu_wd  in  DW  CPU store data
- cpu_rd  out  DW  load data to CPU (equals mem_rd)
- cpu_stall  out  1  CPU must hold its PC and access this cycle
- aux_req  in  1  aux access request; held with aux_we/aux_a/aux_wd stable until granted
- aux_we  in  1  aux write
- aux_a  in  AW  aux byte address
- aux_wd  in  DW  aux write data
- aux_gnt  out  1  aux access performed this cycle
- aux_rvalid  out  1  one-cycle pulse, aux read data valid
- aux_rdata  out  DW  registered aux read data
- mem_we  out  1  to memory we
- mem_a  out  AW  to memory address
- mem_wd  out  DW  to memory write data
- mem_rd  in  DW  from memory read data

Behaviour:
- FSM states:
  - ARB: normal arbitration.
  - POST: the one cycle after a forced grant.
- Wait counter: starve = (wait_cnt == MAX_WAIT).
- In ARB:
  - aux_gnt = aux_req & (~cpu_req | starve).
  - cpu_stall = aux_gnt & cpu_req.
- In POST:
  - aux_gnt = 0 and cpu_stall = 0 regardless of inputs.
  - Always returns to ARB next cycle.
- Transition ARB→POST only when aux_gnt & cpu_req (forced grant). A grant while the CPU is idle stays in ARB, so back-to-back aux grants are allowed when cpu_req=0.
- Memory mux, combinational:
  - aux_gnt=1: mem_we/mem_a/mem_wd = aux_we/aux_a/aux_wd.
  - Otherwise: mem_we = cpu_req & cpu_we; mem_a = cpu_a; mem_wd = cpu_wd.
  - A CPU store is never written while cpu_stall=1.
- cpu_rd = mem_rd, combinational. It is don't-care while cpu_stall=1.
- wait_cnt update:
  - Clears when aux_gnt=1 or aux_req=0.
  - Otherwise increments, saturating at MAX_WAIT.
  - Does not increment in POST (holds).
- Aux read (granted, aux_we=0): aux_rdata <= mem_rd at that edge; aux_rvalid=1 for the following cycle only.
- aux_rdata holds until the next granted aux read. Aux writes produce no rvalid.
- Latency:
  - Aux read, CPU idle: grant same cycle, data +1 cycle.
  - Aux read, CPU continuously busy: grant after MAX_WAIT blocked cycles, data +1 cycle.
- Reset (while reset=1, and registers at the edge):
  - Registers: state=ARB, wait_cnt=0, aux_rvalid=0, aux_rdata=0.
  - Combinational outputs forced: aux_gnt=0, cpu_stall=0, mem_we=0.
- Reset mid-operation: a pending aux request is dropped from the counter's view; the master keeps aux_req high and is re-arbitrated after reset deasserts. An rvalid pending at reset is suppressed.
- Simultaneous aux_req deassert with starve: no grant; counter clears.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds output ports:
  - stall_count (32): CPU stall cycles.
  - aux_grant_count (32): aux grants.
- Counter rules: both increment on their event, wrap at 2^32, and reset to 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - State enum arb_state_t {ARB, POST}.
  - MAX_WAIT default constant.
  - Default DW/AW localparams.
- Sub-module arb_wait_counter: saturating counter with clear, hold and inc inputs, and a starve output. Parameterised by MAX_WAIT.

Test Plan:
- CPU idle, aux read at 0x08 with RAM[2]=0x0000_0005: aux_gnt same cycle; aux_rvalid next cycle; aux_rdata=0x5.
- cpu_req held 1 with loads; aux_req raised at cycle 10, MAX_WAIT=4: aux_gnt and cpu_stall at cycle 14; state POST at 15 with gnt=0; cpu_stall=0 at 15.
- Forced aux write 0xDEAD_BEEF to 0x0C while CPU attempts a store of 0x1111 to 0x0C: memory holds 0xDEAD_BEEF; the CPU store completes the next cycle, leaving 0x1111.
- aux_req held with cpu_req=0 for 3 cycles: three consecutive grants, no POST, cpu_stall never 1.
- reset asserted at cycle 3 of an aux wait: gnt/stall/mem_we=0 during reset; wait_cnt restarts from 0; grant occurs MAX_WAIT cycles after release.
- DMEM_ARB_STATS_EN defined, scenario 2 repeated twice: stall_count=2; aux_grant_count=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
// Contents:
//   arb_state_t      - ARB (normal arbitration) / POST (cycle after a forced aux grant)
//   MAX_WAIT_DEFAULT - blocked aux cycles before a forced grant
//   DW_DEFAULT       - data width
//   AW_DEFAULT       - address width
package dmem_arb_pkg;
    typedef enum logic {ARB = 1'b0, POST = 1'b1} arb_state_t;
    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int DW_DEFAULT       = 32;
    localparam int AW_DEFAULT       = 32;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of blocked aux cycles with clear and hold.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   clr_i    in  clear to zero (wins over hold)
//   hold_i   in  keep the current value
//   inc_i    in  increment, saturating at MAX_WAIT
//   starve_o out count has reached MAX_WAIT
module arb_wait_counter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic hold_i,
    input  logic inc_i,
    output logic starve_o
);
    localparam logic [WAIT_W-1:0] SAT = WAIT_W'(MAX_WAIT);
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d    = clr_i ? '0 : (hold_i || !inc_i || cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
        starve_o = cnt_q == SAT;
    end
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and one aux master.
// The CPU has fixed priority; after MAX_WAIT blocked cycles the aux master is forced
// in for one cycle (CPU stalled), followed by one POST cycle in which the CPU always wins.
// Optional build macro DMEM_ARB_STATS_EN adds stall_count and aux_grant_count outputs.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_a/cpu_wd     CPU load/store request
//   cpu_rd                          load data to CPU (memory read data)
//   cpu_stall                       CPU must hold its access this cycle
//   aux_req/aux_we/aux_a/aux_wd     aux request, held stable until granted
//   aux_gnt                         aux access performed this cycle
//   aux_rvalid/aux_rdata            registered aux read data, one-cycle valid pulse
//   mem_we/mem_a/mem_wd/mem_rd      memory interface (combinational read)
//   stall_count, aux_grant_count    event counters (DMEM_ARB_STATS_EN only)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_a,
    input  logic [DW-1:0] aux_wd,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stall_count,
    output logic [31:0]   aux_grant_count
`endif
);
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be >= 1");
    end

    arb_state_t    state_q, state_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          starve;

    // A stalled CPU is always on the aux side of the mux, so its store is never written.
    always_comb begin
        aux_gnt   = !reset && state_q == ARB && aux_req && (!cpu_req || starve);
        cpu_stall = aux_gnt && cpu_req;
        mem_we    = !reset && (aux_gnt ? aux_we : cpu_req && cpu_we);
        mem_a     = aux_gnt ? aux_a : cpu_a;
        mem_wd    = aux_gnt ? aux_wd : cpu_wd;
        cpu_rd    = mem_rd;
        state_d   = cpu_stall ? POST : ARB;
        rvalid_d  = aux_gnt && !aux_we;
        rdata_d   = rvalid_d ? mem_rd : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign aux_rvalid = rvalid_q;
    assign aux_rdata  = rdata_q;

    // Counts blocked aux cycles; frozen during POST so the CPU gets its guaranteed slot.
    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (aux_gnt || !aux_req),
        .hold_i   (state_q == POST),
        .inc_i    (aux_req),
        .starve_o (starve)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q, gnt_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(cpu_stall);
            gnt_cnt_q   <= gnt_cnt_q + 32'(aux_gnt);
        end
    end
    assign stall_count     = stall_cnt_q;
    assign aux_grant_count = gnt_cnt_q;
`endif
endmodule
